button_stepper: RTL

- Sits directly downstream of the button debouncer on the iCEBreaker wrapper.
- Turns the debounced button level into single-cycle step strobes in the system clock domain: one strobe on press, then auto-repeat strobes while the button is held.
- Replaces driving the LFSR clock from a button. The LFSR runs on clk_i and uses step_o as its clock enable.
- Also reports long-press and release events and a wrapping step counter for LED or debug use.

---
 rtl/lfsr_fpga_pkg.sv | 19 +
 rtl/button_stepper.sv | 113 +++++++++++
 2 files changed

// File: rtl/lfsr_fpga_pkg.sv
// Shared types and timing constants for the LFSR board wrapper.
// Cycle counts for the button stepper are derived from these constants.
package lfsr_fpga_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE    = 2'd0,
    BTN_PRESSED = 2'd1,
    BTN_REPEAT  = 2'd2
  } btn_state_e;

  localparam int unsigned CLK_HZ    = 12_000_000;
  localparam int unsigned HOLD_MS   = 1000;
  localparam int unsigned REPEAT_MS = 250;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/button_stepper.sv
// Debounced button level -> single-cycle step strobes with auto-repeat,
// plus long-press level, release strobe and a wrapping step counter.
module button_stepper
  import lfsr_fpga_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = ms_to_cycles(HOLD_MS),
  parameter int unsigned REPEAT_CYCLES = ms_to_cycles(REPEAT_MS),
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clean_i,
  output logic             step_o,
  output logic             long_o,
  output logic             release_o,
  output logic [CNT_W-1:0] step_cnt_o
);

  localparam int unsigned MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("button_stepper: HOLD_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("button_stepper: REPEAT_CYCLES must be >= 1");
  end

  btn_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             long_q, long_d;
  logic             rel_q, rel_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= BTN_IDLE;
      cnt_q      <= '0;
      step_q     <= 1'b0;
      long_q     <= 1'b0;
      rel_q      <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      long_q     <= long_d;
      rel_q      <= rel_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  // Release is checked first in every held state so it beats a terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    rel_d   = 1'b0;
    long_d  = long_q;
    case (state_q)
      BTN_IDLE: begin
        long_d = 1'b0;
        if (clean_i) begin
          state_d = BTN_PRESSED;
          step_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      BTN_PRESSED: begin
        if (!clean_i) begin
          state_d = BTN_IDLE;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = BTN_REPEAT;
          step_d  = 1'b1;
          long_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BTN_REPEAT: begin
        if (!clean_i) begin
          state_d = BTN_IDLE;
          rel_d   = 1'b1;
          long_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          step_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = BTN_IDLE;
        cnt_d   = '0;
        long_d  = 1'b0;
      end
    endcase
    step_cnt_d = step_cnt_q + CNT_W'(step_d);
  end

  assign step_o     = step_q;
  assign long_o     = long_q;
  assign release_o  = rel_q;
  assign step_cnt_o = step_cnt_q;

endmodule
